// File: rtl/button_conditioner_if.sv
// rtl/button_conditioner_if.sv - button conditioner signal bundle
interface button_conditioner_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] raw_buttons;
  logic             clear_latched;
  logic [WIDTH-1:0] debounced;
  logic [WIDTH-1:0] press_pulse;
  logic [WIDTH-1:0] release_pulse;
  logic [WIDTH-1:0] press_latched;
  logic             any_pressed;

  // Driver side: supplies raw levels and the clear strobe, observes results.
  modport master (
    output raw_buttons,
    output clear_latched,
    input  debounced,
    input  press_pulse,
    input  release_pulse,
    input  press_latched,
    input  any_pressed
  );

  // Conditioner side.
  modport slave (
    input  raw_buttons,
    input  clear_latched,
    output debounced,
    output press_pulse,
    output release_pulse,
    output press_latched,
    output any_pressed
  );
endinterface

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - synchronize, debounce and edge-detect pushbuttons
module button_conditioner #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input logic                 clk,
  input logic                 reset,
  button_conditioner_if.slave bus
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]            sync1_q, sync1_d;
  logic [WIDTH-1:0]            sync2_q, sync2_d;
  logic [WIDTH-1:0]            debounced_q, debounced_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]            press_pulse_q, press_pulse_d;
  logic [WIDTH-1:0]            release_pulse_q, release_pulse_d;
  logic [WIDTH-1:0]            press_latched_q, press_latched_d;

  // Next-state: two-flop synchronizer, per-channel run counter, edge events, sticky flags.
  always_comb begin
    sync1_d     = bus.raw_buttons;
    sync2_d     = sync1_q;
    debounced_d = debounced_q;
    cnt_d       = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] == debounced_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        debounced_d[i] = sync2_q[i];
        cnt_d[i]       = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    press_pulse_d   = debounced_d & ~debounced_q;
    release_pulse_d = ~debounced_d & debounced_q;
    // A press arriving with the clear strobe survives it.
    press_latched_d = (press_latched_q & ~{WIDTH{bus.clear_latched}}) | press_pulse_d;
  end

  // State registers; reset discards any debounce progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q         <= '0;
      sync2_q         <= '0;
      debounced_q     <= '0;
      cnt_q           <= '0;
      press_pulse_q   <= '0;
      release_pulse_q <= '0;
      press_latched_q <= '0;
    end else begin
      sync1_q         <= sync1_d;
      sync2_q         <= sync2_d;
      debounced_q     <= debounced_d;
      cnt_q           <= cnt_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      press_latched_q <= press_latched_d;
    end
  end

  assign bus.debounced     = debounced_q;
  assign bus.press_pulse   = press_pulse_q;
  assign bus.release_pulse = release_pulse_q;
  assign bus.press_latched = press_latched_q;
  assign bus.any_pressed   = |press_latched_q;
endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed self-checking bench for button_conditioner
module tb_button_conditioner;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  button_conditioner_if #(.WIDTH(4)) bus ();
  button_conditioner_if #(.WIDTH(1)) bus1 ();

  button_conditioner #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  button_conditioner #(.WIDTH(1), .DEBOUNCE_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run time exceeded");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.raw_buttons = 4'b0000; bus.clear_latched = 1'b0;
    bus1.raw_buttons = 1'b0;   bus1.clear_latched = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++; if (bus.debounced !== 4'b0000) begin fails++; $display("FAIL reset_debounced got %b want 0000", bus.debounced); end
    tests++; if (bus.press_pulse !== 4'b0000 || bus.release_pulse !== 4'b0000) begin fails++; $display("FAIL reset_pulses got %b/%b want 0000/0000", bus.press_pulse, bus.release_pulse); end
    tests++; if (bus.press_latched !== 4'b0000 || bus.any_pressed !== 1'b0) begin fails++; $display("FAIL reset_latched got %b/%b want 0000/0", bus.press_latched, bus.any_pressed); end
    tests++; if (dut.cnt_q !== '0) begin fails++; $display("FAIL reset_counters got %h want 0", dut.cnt_q); end
  endtask

  task automatic test_min_debounce();
    bus1.raw_buttons = 1'b1;
    tick();
    tick();
    tests++; if (bus1.debounced !== 1'b0) begin fails++; $display("FAIL min_early got %b want 0 at E0+1", bus1.debounced); end
    tick();
    tests++; if (bus1.debounced !== 1'b1 || bus1.press_pulse !== 1'b1) begin fails++; $display("FAIL min_rise got %b/%b want 1/1 at E0+2", bus1.debounced, bus1.press_pulse); end
  endtask

  task automatic test_press();
    int bad = 0;
    bus.raw_buttons = 4'b0110;
    for (int k = 0; k <= 4; k++) begin
      tick();
      if (bus.debounced !== 4'b0000 || bus.press_pulse !== 4'b0000) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL press_wait got %0d early changes want 0", bad); end
    tick();
    tests++; if (bus.debounced !== 4'b0110) begin fails++; $display("FAIL press_debounced got %b want 0110", bus.debounced); end
    tests++; if (bus.press_pulse !== 4'b0110) begin fails++; $display("FAIL press_pulse got %b want 0110", bus.press_pulse); end
    tests++; if (bus.press_latched !== 4'b0110 || bus.any_pressed !== 1'b1) begin fails++; $display("FAIL press_latched got %b/%b want 0110/1", bus.press_latched, bus.any_pressed); end
    tick();
    tests++; if (bus.press_pulse !== 4'b0000) begin fails++; $display("FAIL press_pulse_width got %b want 0000", bus.press_pulse); end
  endtask

  task automatic test_glitch();
    int bad = 0;
    bus.raw_buttons = 4'b0111;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (bus.debounced !== 4'b0110 || bus.press_pulse !== 4'b0000) bad++;
    end
    bus.raw_buttons = 4'b0110;
    tick();
    if (bus.debounced !== 4'b0110 || bus.press_pulse !== 4'b0000) bad++;
    bus.raw_buttons = 4'b0111;
    for (int k = 0; k <= 4; k++) begin
      tick();
      if (bus.debounced !== 4'b0110 || bus.press_pulse !== 4'b0000) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL glitch_hold got %0d early changes want 0", bad); end
    tick();
    tests++; if (bus.debounced !== 4'b0111 || bus.press_pulse !== 4'b0001) begin fails++; $display("FAIL glitch_rise got %b/%b want 0111/0001", bus.debounced, bus.press_pulse); end
    tick();
    tests++; if (bus.press_pulse !== 4'b0000) begin fails++; $display("FAIL glitch_single_pulse got %b want 0000", bus.press_pulse); end
  endtask

  task automatic test_release();
    int bad = 0;
    bus.raw_buttons = 4'b0000;
    for (int k = 0; k <= 4; k++) begin
      tick();
      if (bus.debounced !== 4'b0111 || bus.release_pulse !== 4'b0000) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL release_wait got %0d early changes want 0", bad); end
    tick();
    tests++; if (bus.debounced !== 4'b0000 || bus.release_pulse !== 4'b0111) begin fails++; $display("FAIL release_fall got %b/%b want 0000/0111", bus.debounced, bus.release_pulse); end
    tests++; if (bus.press_latched !== 4'b0111) begin fails++; $display("FAIL release_sticky got %b want 0111", bus.press_latched); end
    tick();
    tests++; if (bus.release_pulse !== 4'b0000 || bus.press_latched !== 4'b0111) begin fails++; $display("FAIL release_after got %b/%b want 0000/0111", bus.release_pulse, bus.press_latched); end
    bus.clear_latched = 1'b1;
    tick();
    bus.clear_latched = 1'b0;
    tests++; if (bus.press_latched !== 4'b0000 || bus.any_pressed !== 1'b0) begin fails++; $display("FAIL release_clear got %b/%b want 0000/0", bus.press_latched, bus.any_pressed); end
  endtask

  task automatic test_clear_collision();
    bus.raw_buttons = 4'b0010;
    for (int k = 0; k <= 5; k++) tick();
    tests++; if (bus.press_latched !== 4'b0010) begin fails++; $display("FAIL collide_setup got %b want 0010", bus.press_latched); end
    bus.raw_buttons = 4'b1010;
    for (int k = 0; k <= 4; k++) tick();
    bus.clear_latched = 1'b1;
    tick();
    bus.clear_latched = 1'b0;
    tests++; if (bus.debounced !== 4'b1010 || bus.press_pulse !== 4'b1000) begin fails++; $display("FAIL collide_rise got %b/%b want 1010/1000", bus.debounced, bus.press_pulse); end
    tests++; if (bus.press_latched !== 4'b1000 || bus.any_pressed !== 1'b1) begin fails++; $display("FAIL collide_latched got %b/%b want 1000/1", bus.press_latched, bus.any_pressed); end
  endtask

  task automatic test_reset_mid_debounce();
    int bad = 0;
    bus.raw_buttons = 4'b1110;
    for (int k = 0; k <= 3; k++) tick();
    tests++; if (dut.cnt_q[2] !== 3'd2) begin fails++; $display("FAIL midreset_count got %0d want 2", dut.cnt_q[2]); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++; if (bus.debounced !== 4'b0000 || bus.press_latched !== 4'b0000 || bus.any_pressed !== 1'b0 || bus.press_pulse !== 4'b0000 || bus.release_pulse !== 4'b0000) begin
      fails++; $display("FAIL midreset_outputs got %b/%b/%b/%b/%b want zeros", bus.debounced, bus.press_latched, bus.any_pressed, bus.press_pulse, bus.release_pulse);
    end
    for (int k = 0; k <= 4; k++) begin
      tick();
      if (bus.debounced !== 4'b0000) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL midreset_wait got %0d early changes want 0", bad); end
    tick();
    tests++; if (bus.debounced !== 4'b1110 || bus.press_pulse !== 4'b1110 || bus.press_latched !== 4'b1110) begin
      fails++; $display("FAIL midreset_rise got %b/%b/%b want 1110/1110/1110", bus.debounced, bus.press_pulse, bus.press_latched);
    end
  endtask

  task automatic test_hold();
    int pc[4] = '{0, 0, 0, 0};
    int bad = 0;
    bus.raw_buttons = 4'b1111;
    for (int k = 0; k < 56; k++) begin
      tick();
      for (int b = 0; b < 4; b++) if (bus.press_pulse[b] === 1'b1) pc[b]++;
      if (k >= 5 && bus.debounced !== 4'b1111) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL hold_level got %0d bad samples want 0", bad); end
    tests++; if (pc[0] != 1 || pc[1] != 0 || pc[2] != 0 || pc[3] != 0) begin fails++; $display("FAIL hold_pulses got %0d %0d %0d %0d want 1 0 0 0", pc[0], pc[1], pc[2], pc[3]); end
    tests++; if (dut.cnt_q !== '0) begin fails++; $display("FAIL hold_counters got %h want 0", dut.cnt_q); end
    tests++; if (bus.press_latched !== 4'b1111 || bus.any_pressed !== 1'b1) begin fails++; $display("FAIL hold_latched got %b/%b want 1111/1", bus.press_latched, bus.any_pressed); end
  endtask

  initial begin
    test_reset();
    test_min_debounce();
    test_press();
    test_glitch();
    test_release();
    test_clear_collision();
    test_reset_mid_debounce();
    test_hold();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
